// File: rtl/mmu_pkg.sv
// Shared types, fixed addresses and address decode for the MMU.
package mmu_pkg;

    typedef enum logic [2:0] {
        REG_WRAM,
        REG_ECHO,
        REG_HRAM,
        REG_IE,
        REG_DMA,
        REG_BOOT,
        REG_EXT
    } region_t;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_STARTUP,
        DMA_XFER
    } dma_state_t;

    localparam logic [15:0] ADDR_DMA  = 16'hFF46;
    localparam logic [15:0] ADDR_BOOT = 16'hFF50;
    localparam logic [15:0] ADDR_HRAM = 16'hFF80;
    localparam logic [15:0] ADDR_OAM  = 16'hFE00;

    function automatic region_t decode(input logic [15:0] addr);
        region_t r;
        if (addr >= 16'hC000 && addr <= 16'hDFFF) r = REG_WRAM;
        else if (addr >= 16'hE000 && addr <= 16'hFDFF) r = REG_ECHO;
        else if (addr == 16'hFFFF) r = REG_IE;
        else if (addr >= ADDR_HRAM) r = REG_HRAM;
        else if (addr == ADDR_DMA) r = REG_DMA;
        else if (addr == ADDR_BOOT) r = REG_BOOT;
        else r = REG_EXT;
        return r;
    endfunction

endpackage

// File: rtl/bus_if.sv
// CPU bus between the core and the MMU.
interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        read_en;
    logic        write_en;
    logic [7:0]  rdata;

    modport MMU_side (input addr, input wdata, input read_en, input write_en, output rdata);
    modport CPU_side (output addr, output wdata, output read_en, output write_en, input rdata);
endinterface

// File: rtl/mmu_oam_dma.sv
// OAM DMA engine: 4-clk startup, then one byte per 4-clk slot (read, latch, write, idle).
module oam_dma
    import mmu_pkg::*;
#(
    parameter int unsigned DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  page,
    input  logic [7:0]  src_data,
    output logic        active,
    output logic [15:0] src_addr,
    output logic [15:0] oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_data
);

    localparam int unsigned IDX_W = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DMA_LEN - 1);

    dma_state_t       state;
    logic [1:0]       phase;
    logic [IDX_W-1:0] idx;
    logic [7:0]       src_page;

    assign src_addr = {src_page, 8'h00} + 16'(idx);
    assign oam_addr = ADDR_OAM + 16'(idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DMA_IDLE;
            phase    <= 2'd0;
            idx      <= '0;
            src_page <= 8'h00;
            oam_data <= 8'h00;
            oam_we   <= 1'b0;
            active   <= 1'b0;
        end else begin
            oam_we <= 1'b0;
            unique case (state)
                DMA_IDLE: begin
                    if (start) begin
                        state    <= DMA_STARTUP;
                        active   <= 1'b1;
                        phase    <= 2'd0;
                        idx      <= '0;
                        // Pages E0-FF alias the WRAM echo onto C0-DF.
                        src_page <= (page >= 8'hE0) ? page - 8'h20 : page;
                    end
                end
                DMA_STARTUP: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) state <= DMA_XFER;
                end
                DMA_XFER: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd0) oam_data <= src_data;
                    if (phase == 2'd1) oam_we <= 1'b1;
                    if (phase == 2'd3) begin
                        if (idx == LAST) begin
                            state  <= DMA_IDLE;
                            active <= 1'b0;
                            idx    <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mmu.sv
// Bus decode, internal WRAM/HRAM/IE, FF46/FF50 control and external port muxing.
module mmu
    import mmu_pkg::*;
#(
    parameter int unsigned WRAM_BYTES = 8192,
    parameter int unsigned DMA_LEN    = 160
) (
    input  logic        clk,
    input  logic        reset,
    Bus_if.MMU_side     bus,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    output logic        ext_we,
    input  logic [7:0]  ext_rdata,
    output logic        boot_rom_en,
    output logic        dma_active
);

    localparam int unsigned WA = $clog2(WRAM_BYTES);

    logic [7:0]  wram [WRAM_BYTES];
    logic [7:0]  hram [0:126];

    region_t     region;
    logic        blocked;
    logic        write_en_q;
    logic        commit;
    logic [7:0]  rdata_q;
    logic [7:0]  rdata_d;
    logic [7:0]  ie_q;
    logic [7:0]  dma_reg_q;
    logic        dma_start_q;
    logic        cpu_we_q;
    logic [15:0] cpu_waddr_q;
    logic [7:0]  cpu_wdata_q;

    logic [15:0] dma_src_addr;
    logic [15:0] dma_oam_addr;
    logic        dma_we;
    logic [7:0]  dma_data;
    logic [7:0]  dma_src_data;
    logic        unused_read_en;

    assign unused_read_en = bus.read_en;
    assign region  = decode(bus.addr);
    assign blocked = dma_active && (bus.addr < ADDR_HRAM);
    assign commit  = bus.write_en && !write_en_q && !blocked;

    always_ff @(posedge clk) begin
        if (commit && (region == REG_WRAM || region == REG_ECHO)) wram[bus.addr[WA-1:0]] <= bus.wdata;
        if (commit && region == REG_HRAM) hram[bus.addr[6:0]] <= bus.wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en_q  <= 1'b0;
            ie_q        <= 8'h00;
            dma_reg_q   <= 8'h00;
            dma_start_q <= 1'b0;
            boot_rom_en <= 1'b1;
            cpu_we_q    <= 1'b0;
            cpu_waddr_q <= 16'h0000;
            cpu_wdata_q <= 8'h00;
            rdata_q     <= 8'hFF;
        end else begin
            write_en_q  <= bus.write_en;
            dma_start_q <= 1'b0;
            cpu_we_q    <= 1'b0;
            rdata_q     <= rdata_d;
            if (commit) begin
                case (region)
                    REG_IE: ie_q <= bus.wdata;
                    REG_DMA: begin
                        dma_reg_q   <= bus.wdata;
                        dma_start_q <= 1'b1;
                    end
                    REG_BOOT: if (bus.wdata != 8'h00) boot_rom_en <= 1'b0;
                    REG_EXT: begin
                        cpu_we_q    <= 1'b1;
                        cpu_waddr_q <= bus.addr;
                        cpu_wdata_q <= bus.wdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata_d = 8'hFF;
        if (!blocked) begin
            case (region)
                REG_WRAM, REG_ECHO: rdata_d = wram[bus.addr[WA-1:0]];
                REG_HRAM:           rdata_d = hram[bus.addr[6:0]];
                REG_IE:             rdata_d = ie_q;
                REG_DMA:            rdata_d = dma_reg_q;
                REG_BOOT:           rdata_d = {7'h7F, ~boot_rom_en};
                default:            rdata_d = ext_rdata;
            endcase
        end
    end

    assign bus.rdata = rdata_q;

    // WRAM sources bypass the external port; the DMA source page is already echo-remapped.
    assign dma_src_data = (dma_src_addr[15:13] == 3'b110) ? wram[dma_src_addr[WA-1:0]] : ext_rdata;

    assign ext_addr  = dma_active ? (dma_we ? dma_oam_addr : dma_src_addr)
                                  : (cpu_we_q ? cpu_waddr_q : bus.addr);
    assign ext_wdata = dma_active ? dma_data : cpu_wdata_q;
    assign ext_we    = dma_we | cpu_we_q;

    oam_dma #(
        .DMA_LEN (DMA_LEN)
    ) u_oam_dma (
        .clk      (clk),
        .reset    (reset),
        .start    (dma_start_q),
        .page     (dma_reg_q),
        .src_data (dma_src_data),
        .active   (dma_active),
        .src_addr (dma_src_addr),
        .oam_addr (dma_oam_addr),
        .oam_we   (dma_we),
        .oam_data (dma_data)
    );

endmodule

// File: doc/mmu.md
# mmu

Memory-management unit directly downstream of the CPU bus port. It decodes every CPU bus transaction and serves three kinds of target: internal WRAM, HRAM and the IE register, the control registers FF46 (OAM DMA) and FF50 (boot-ROM disable), and an external port for everything else (cartridge, VRAM, OAM, I/O). It also contains the OAM DMA engine. While a DMA is running, the engine takes ownership of the bus and locks the CPU out of every address below FF80.

## Interface
Parameters:
- WRAM_BYTES, 8192: WRAM size. Mapped at C000-DFFF, echoed at E000-FDFF.
- DMA_LEN, 160: bytes per OAM DMA.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- bus  Bus_if.MMU_side  –  CPU bus:
  - addr[15:0], wdata[7:0], read_en, write_en come in.
  - rdata[7:0] goes out.
- ext_addr  out  16  external address.
- ext_wdata  out  8  external write data.
- ext_we  out  1  external write strobe, one clk per write.
- ext_rdata  in  8  external read data, combinational from ext_addr.
- boot_rom_en  out  1  boot-ROM overlay of 0000-00FF is active.
- dma_active  out  1  OAM DMA in progress.

## Operation
- Decode:
  - C000-FDFF → WRAM, index addr[12:0].
  - FF80-FFFE → HRAM, 127 B.
  - FFFF → IE.
  - FF46 → DMA register.
  - FF50 → boot register.
  - All other addresses → external port.
- Reads:
  - rdata is registered every clk from the current addr, independent of read_en.
  - FF46 reads return the last value written.
  - FF50 reads return {7'h7F, ~boot_rom_en}.
- Writes:
  - A write commits only on the rising edge of write_en (write_en & ~write_en_q). The CPU holds write_en high for 2 clks, and it must commit exactly once.
  - External writes pulse ext_we for 1 clk with ext_addr = addr.
- Boot: a write to FF50 with a nonzero value clears boot_rom_en. It stays cleared until reset.
- DMA start: a write of value P to FF46, while idle, latches src = {P,8'h00}. It then enters STARTUP.
- DMA state machine, IDLE → STARTUP → XFER → IDLE:
  - STARTUP lasts 4 clks.
  - XFER moves one byte per 4-clk slot. Index i runs 0..DMA_LEN-1.
  - Slot phase 0: read source src+i. If the source page is ≥ E0, it maps to the WRAM echo (page-0x20).
  - Slot phase 1: the byte is latched.
  - Slot phase 2: ext_we=1, ext_addr=FE00+i.
  - Slot phase 3: idle.
  - After i = DMA_LEN-1 completes phase 3 → IDLE.
- During a DMA (dma_active=1):
  - CPU accesses to addresses < FF80 are blocked. Blocked reads return FF. Blocked writes, including to FF46 and FF50, are dropped.
  - HRAM and IE remain fully accessible.
  - The DMA owns ext_addr. CPU traffic never reaches the external port.
- Source reads from WRAM use the internal array. All other sources use ext_addr/ext_rdata.

## Timing
- Reset values:
  - rdata=FF.
  - ext_we=0, ext_addr=0000, ext_wdata=00.
  - boot_rom_en=1, dma_active=0, IE=00, FF46=00.
  - State IDLE, i=0.
  - WRAM and HRAM contents are undefined.
- Read latency is 1 clk: addr is stable at edge n, so rdata is valid at edge n+1. This matches the CPU's T1-addr / T3-sample window.
- Write: committed at the first edge where write_en is seen high.
- dma_active rises at the edge after the FF46 write commits. It stays high for 4 + 4·DMA_LEN clks (644 for the default DMA_LEN).
- The byte-i ext_we pulse occurs 4 + 4i + 2 clks after dma_active rises.
- A CPU HRAM access in the same clk as a DMA WRAM read is served without conflict.
- Asserting reset mid-DMA aborts immediately. No further ext_we pulses occur.

## Structure
- Shared package mmu_pkg:
  - Region enum: REG_WRAM, REG_ECHO, REG_HRAM, REG_IE, REG_DMA, REG_BOOT, REG_EXT.
  - dma_state_t.
  - Address constants: FF46, FF50, FF80, FE00.
  - The decode function.
- Sub-module oam_dma: holds the state machine, slot counter and index. It requests source reads and issues OAM writes. The mmu top level owns the memories and muxing.

## Test plan
- Reset → rdata=FF, boot_rom_en=1, dma_active=0, ext_we=0.
- Write 5A to C123, then read E123 → rdata=5A one clk after addr is presented. Exactly one commit occurs across the 2-clk write_en.
- Write 01 to FF50 → boot_rom_en=0. A later write of 00 to FF50 leaves it at 0. Reset restores 1.
- Fill C000-C09F with i^A5, then write C0 to FF46:
  - Exactly 160 ext_we pulses occur.
  - Pulse k carries ext_addr=FE00+k and ext_wdata=k^A5.
  - dma_active is high for 644 clks.
- During that DMA:
  - Read C000 → FF.
  - Write FF80=3C, then read it back → 3C.
  - Write FF46 → ignored; the transfer count stays 160.
- Assert reset after byte 10 of a DMA → dma_active=0 at once, and no ext_we occurs afterwards.
